// File: rtl/load_store_unit_if.sv
// Request/response and memory-bus signals between the datapath, the
// load/store controller and the byte-addressed big-endian data memory.
interface load_store_unit_if;
   logic        req;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;

   modport master (
      output req, op, addr, wdata, ReadData,
      input  busy, done, err, rdata, Address, WriteData, MemWrite, MemRead
   );

   modport slave (
      input  req, op, addr, wdata, ReadData,
      output busy, done, err, rdata, Address, WriteData, MemWrite, MemRead
   );
endinterface

// File: rtl/load_store_unit.sv
// One-at-a-time load/store controller: edge-triggered memory strobes, sub-word
// extraction with sign/zero extension, read-modify-write for SB/SH, range/alignment checks.
module load_store_unit #(
   parameter int unsigned MEM_BYTES = 256
) (
   input logic             clk,
   input logic             reset,
   load_store_unit_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_MERGE, S_WR, S_FIN
   } state_t;

   typedef enum logic [2:0] {
      OP_LB  = 3'b000,
      OP_LH  = 3'b001,
      OP_LW  = 3'b010,
      OP_LBU = 3'b011,
      OP_LHU = 3'b100,
      OP_SB  = 3'b101,
      OP_SH  = 3'b110,
      OP_SW  = 3'b111
   } op_t;

   state_t      r_state;
   op_t         r_op;
   logic [1:0]  r_lane;
   logic [15:0] r_wdata;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic [31:0] r_rdata;
   logic [31:0] r_Address;
   logic [31:0] r_WriteData;
   logic        r_MemWrite;
   logic        r_MemRead;

   logic        w_is_load;
   logic        w_misaligned;
   logic        w_out_of_range;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_val;
   logic [31:0] w_merge;

   assign w_is_load      = (bus.op <= OP_LHU);
   assign w_out_of_range = (bus.addr >= 32'(MEM_BYTES));

   always_comb begin
      w_misaligned = 1'b0;
      case (op_t'(bus.op))
         OP_LW, OP_SW:          w_misaligned = (bus.addr[1:0] != 2'b00);
         OP_LH, OP_LHU, OP_SH:  w_misaligned = bus.addr[0];
         default:               w_misaligned = 1'b0;
      endcase
   end

   // Lane 0 is the most significant byte (big-endian).
   always_comb begin
      w_byte = bus.ReadData[31:24];
      case (r_lane)
         2'd0: w_byte = bus.ReadData[31:24];
         2'd1: w_byte = bus.ReadData[23:16];
         2'd2: w_byte = bus.ReadData[15:8];
         2'd3: w_byte = bus.ReadData[7:0];
         default: w_byte = bus.ReadData[31:24];
      endcase
      w_half = r_lane[1] ? bus.ReadData[15:0] : bus.ReadData[31:16];
   end

   always_comb begin
      w_load_val = bus.ReadData;
      case (r_op)
         OP_LB:   w_load_val = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  w_load_val = {24'h0, w_byte};
         OP_LH:   w_load_val = {{16{w_half[15]}}, w_half};
         OP_LHU:  w_load_val = {16'h0, w_half};
         default: w_load_val = bus.ReadData;
      endcase
   end

   always_comb begin
      w_merge = bus.ReadData;
      if (r_op == OP_SB) begin
         case (r_lane)
            2'd0: w_merge[31:24] = r_wdata[7:0];
            2'd1: w_merge[23:16] = r_wdata[7:0];
            2'd2: w_merge[15:8]  = r_wdata[7:0];
            2'd3: w_merge[7:0]   = r_wdata[7:0];
            default: w_merge = bus.ReadData;
         endcase
      end else if (r_lane[1]) begin
         w_merge[15:0] = r_wdata;
      end else begin
         w_merge[31:16] = r_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_op        <= OP_LB;
         r_lane      <= '0;
         r_wdata     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_rdata     <= '0;
         r_Address   <= '0;
         r_WriteData <= '0;
         r_MemWrite  <= 1'b0;
         r_MemRead   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.req) begin
                  r_op      <= op_t'(bus.op);
                  r_lane    <= bus.addr[1:0];
                  r_wdata   <= bus.wdata[15:0];
                  r_Address <= {bus.addr[31:2], 2'b00};
                  r_busy    <= 1'b1;
                  r_err     <= 1'b0;
                  if (w_misaligned || w_out_of_range) begin
                     r_err   <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
                     if (w_is_load) r_rdata <= '0;
                  end else if (op_t'(bus.op) == OP_SW) begin
                     r_WriteData <= bus.wdata;
                     r_MemWrite  <= 1'b1;
                     r_state     <= S_WR;
                  end else begin
                     r_MemRead <= 1'b1;
                     r_state   <= S_RD;
                  end
               end
            end
            S_RD: begin
               r_MemRead <= 1'b0;
               if (r_op <= OP_LHU) begin
                  r_rdata <= w_load_val;
                  r_done  <= 1'b1;
                  r_state <= S_FIN;
               end else begin
                  r_WriteData <= w_merge;
                  r_state     <= S_MERGE;
               end
            end
            S_MERGE: begin
               r_MemWrite <= 1'b1;
               r_state    <= S_WR;
            end
            S_WR: begin
               r_MemWrite <= 1'b0;
               r_done     <= 1'b1;
               r_state    <= S_FIN;
            end
            S_FIN: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy     <= 1'b0;
               r_MemRead  <= 1'b0;
               r_MemWrite <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.err       = r_err;
   assign bus.rdata     = r_rdata;
   assign bus.Address   = r_Address;
   assign bus.WriteData = r_WriteData;
   assign bus.MemWrite  = r_MemWrite;
   assign bus.MemRead   = r_MemRead;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: edge-triggered memory device, byte-array reference
// model, directed vector table, multi-cycle corner sequences and random traffic.
module tb_load_store_unit;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   load_store_unit_if bus();

   load_store_unit #(.MEM_BYTES(256)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0]  dev_mem [256];
   logic [7:0]  ref_mem [256];
   logic [31:0] ref_rdata;
   logic [31:0] dev_last_wword = '0;

   int rd_cnt   = 0;
   int wr_cnt   = 0;
   int done_cnt = 0;
   bit prev_strobe = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Memory device: reacts to strobe rising edges only.
   always @(posedge bus.MemRead) begin : mem_rd
      logic [7:0] a;
      #1;
      a = bus.Address[7:0];
      bus.ReadData = {dev_mem[a], dev_mem[8'(a + 1)], dev_mem[8'(a + 2)], dev_mem[8'(a + 3)]};
   end

   always @(posedge bus.MemWrite) begin : mem_wr
      logic [7:0] a;
      #1;
      a = bus.Address[7:0];
      dev_last_wword = bus.WriteData;
      dev_mem[a]           = bus.WriteData[31:24];
      dev_mem[8'(a + 1)]   = bus.WriteData[23:16];
      dev_mem[8'(a + 2)]   = bus.WriteData[15:8];
      dev_mem[8'(a + 3)]   = bus.WriteData[7:0];
   end

   always @(negedge clk) begin
      if (bus.MemRead)  rd_cnt++;
      if (bus.MemWrite) wr_cnt++;
      if (bus.done)     done_cnt++;
      if (bus.MemRead || bus.MemWrite) begin
         n_cmp++;
         if (prev_strobe || (bus.MemRead && bus.MemWrite)) begin
            n_fail++;
            $display("FAIL strobe_spacing: rd=%0b wr=%0b prev=%0b, required isolated single strobe",
                     bus.MemRead, bus.MemWrite, prev_strobe);
         end
      end
      prev_strobe = bus.MemRead || bus.MemWrite;
   end

   // Reference model over a flat byte array; returns expectations for one access.
   function automatic void ref_access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                                      output logic [31:0] rd, output logic er, output int cyc,
                                      output int rdn, output int wrn, output logic [31:0] wword);
      int size;
      bit is_load, sgn;
      logic [31:0] v;
      logic [7:0] base;
      is_load = (op <= 3'd4);
      sgn     = (op == 3'd0) || (op == 3'd1);
      size    = (op == 3'd2 || op == 3'd7) ? 4 : (op == 3'd1 || op == 3'd4 || op == 3'd6) ? 2 : 1;
      er      = (a >= 32'd256) || ((a % size) != 0);
      wword   = '0;
      if (er) begin
         cyc = 1; rdn = 0; wrn = 0;
         if (is_load) ref_rdata = '0;
      end else if (is_load) begin
         v = '0;
         for (int i = 0; i < size; i++) v = (v << 8) | 32'(ref_mem[a + i]);
         if (sgn && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
         ref_rdata = v;
         cyc = 2; rdn = 1; wrn = 0;
      end else begin
         for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8 * (size - 1 - i) +: 8];
         base  = a[7:0] & 8'hFC;
         wword = {ref_mem[base], ref_mem[8'(base + 1)], ref_mem[8'(base + 2)], ref_mem[8'(base + 3)]};
         cyc = (size == 4) ? 2 : 4;
         rdn = (size == 4) ? 0 : 1;
         wrn = 1;
      end
      rd = ref_rdata;
   endfunction

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      bit          chk_rd;
      logic [31:0] exp_wword;
      bit          chk_ww;
   } vec_t;

   task automatic wait_idle(input string tag);
      int guard = 0;
      while ((bus.busy || bus.done) && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) chk({tag, "_idle_timeout"}, 32'(guard), 32'd0);
   endtask

   task automatic run_one(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input bit has_tbl, input vec_t v);
      logic [31:0] m_rd, m_ww;
      logic        m_er;
      int m_cyc, m_rdn, m_wrn, cyc, r0, w0;
      ref_access(op, a, wd, m_rd, m_er, m_cyc, m_rdn, m_wrn, m_ww);
      wait_idle(tag);
      bus.req = 1'b1; bus.op = op; bus.addr = a; bus.wdata = wd;
      r0 = rd_cnt; w0 = wr_cnt;
      @(posedge clk);
      #1 bus.req = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            chk({tag, "_Address"}, bus.Address, {a[31:2], 2'b00});
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
         end
      end while (!bus.done && cyc < 12);
      #1;
      chk({tag, "_done_cycle"}, 32'(cyc), 32'(m_cyc));
      chk({tag, "_err"}, 32'(bus.err), 32'(m_er));
      chk({tag, "_rdata"}, bus.rdata, m_rd);
      chk({tag, "_memread_cycles"}, 32'(rd_cnt - r0), 32'(m_rdn));
      chk({tag, "_memwrite_cycles"}, 32'(wr_cnt - w0), 32'(m_wrn));
      if (m_wrn != 0) chk({tag, "_WriteData"}, dev_last_wword, m_ww);
      if (has_tbl) begin
         chk({tag, "_tbl_err"}, 32'(bus.err), 32'(v.exp_err));
         if (v.chk_rd) chk({tag, "_tbl_rdata"}, bus.rdata, v.exp_rdata);
         if (v.chk_ww) chk({tag, "_tbl_WriteData"}, dev_last_wword, v.exp_wword);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [15];
      vec_t nv;
      logic [31:0] m_rd, m_ww;
      logic        m_er;
      int m_cyc, m_rdn, m_wrn, d0, r0, w0, rsel;
      logic [2:0]  rop;
      logic [31:0] ra;

      tbl[0]  = '{3'd7, 32'h10,  32'h11223344, 32'h0,        1'b0, 1'b0, 32'h11223344, 1'b1};
      tbl[1]  = '{3'd2, 32'h10,  32'h0,        32'h11223344, 1'b0, 1'b1, 32'h0,        1'b0};
      tbl[2]  = '{3'd3, 32'h11,  32'h0,        32'h00000022, 1'b0, 1'b1, 32'h0,        1'b0};
      tbl[3]  = '{3'd7, 32'h20,  32'h80FF7F01, 32'h0,        1'b0, 1'b0, 32'h80FF7F01, 1'b1};
      tbl[4]  = '{3'd0, 32'h20,  32'h0,        32'hFFFFFF80, 1'b0, 1'b1, 32'h0,        1'b0};
      tbl[5]  = '{3'd3, 32'h21,  32'h0,        32'h000000FF, 1'b0, 1'b1, 32'h0,        1'b0};
      tbl[6]  = '{3'd1, 32'h20,  32'h0,        32'hFFFF80FF, 1'b0, 1'b1, 32'h0,        1'b0};
      tbl[7]  = '{3'd4, 32'h22,  32'h0,        32'h00007F01, 1'b0, 1'b1, 32'h0,        1'b0};
      tbl[8]  = '{3'd7, 32'h30,  32'hAABBCCDD, 32'h0,        1'b0, 1'b0, 32'hAABBCCDD, 1'b1};
      tbl[9]  = '{3'd5, 32'h32,  32'h00000012, 32'h0,        1'b0, 1'b0, 32'hAABB12DD, 1'b1};
      tbl[10] = '{3'd6, 32'h30,  32'h00005566, 32'h0,        1'b0, 1'b0, 32'h556612DD, 1'b1};
      tbl[11] = '{3'd2, 32'h30,  32'h0,        32'h556612DD, 1'b0, 1'b1, 32'h0,        1'b0};
      tbl[12] = '{3'd2, 32'h22,  32'h0,        32'h0,        1'b1, 1'b1, 32'h0,        1'b0};
      tbl[13] = '{3'd6, 32'h41,  32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
      tbl[14] = '{3'd0, 32'h100, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0,        1'b0};
      nv = tbl[0];

      for (int i = 0; i < 256; i++) begin
         dev_mem[i] = 8'($urandom);
         ref_mem[i] = dev_mem[i];
      end
      ref_rdata = '0;
      bus.req = 1'b0; bus.op = '0; bus.addr = '0; bus.wdata = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy",      32'(bus.busy),     32'd0);
      chk("rst_done",      32'(bus.done),     32'd0);
      chk("rst_err",       32'(bus.err),      32'd0);
      chk("rst_MemRead",   32'(bus.MemRead),  32'd0);
      chk("rst_MemWrite",  32'(bus.MemWrite), 32'd0);
      chk("rst_rdata",     bus.rdata,         32'd0);
      chk("rst_Address",   bus.Address,       32'd0);
      chk("rst_WriteData", bus.WriteData,     32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 15; i++)
         run_one($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wdata, 1'b1, tbl[i]);

      // Reset while an SB sits in MERGE: no write may reach memory.
      wait_idle("rstmerge");
      bus.req = 1'b1; bus.op = 3'd5; bus.addr = 32'h33; bus.wdata = 32'hEE;
      @(posedge clk);
      #1 bus.req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rstmerge_busy_in_merge", 32'(bus.busy), 32'd1);
      chk("rstmerge_strobes_in_merge", {30'd0, bus.MemRead, bus.MemWrite}, 32'd0);
      w0 = wr_cnt;
      reset = 1'b1;
      @(negedge clk);
      chk("rstmerge_busy",     32'(bus.busy),     32'd0);
      chk("rstmerge_MemWrite", 32'(bus.MemWrite), 32'd0);
      chk("rstmerge_done",     32'(bus.done),     32'd0);
      chk("rstmerge_rdata",    bus.rdata,         32'd0);
      reset = 1'b0;
      ref_rdata = '0;
      repeat (4) @(negedge clk);
      chk("rstmerge_no_write", 32'(wr_cnt - w0), 32'd0);
      run_one("rstmerge_readback", 3'd2, 32'h30, 32'h0, 1'b0, nv);

      // Back-to-back LW with req held: one access per 3 cycles, none queued.
      wait_idle("b2b");
      ref_access(3'd2, 32'h10, 32'h0, m_rd, m_er, m_cyc, m_rdn, m_wrn, m_ww);
      d0 = done_cnt; r0 = rd_cnt;
      bus.req = 1'b1; bus.op = 3'd2; bus.addr = 32'h10;
      repeat (8) @(posedge clk);
      @(negedge clk);
      bus.req = 1'b0;
      repeat (4) @(negedge clk);
      chk("b2b_done_count", 32'(done_cnt - d0), 32'd3);
      chk("b2b_read_count", 32'(rd_cnt - r0),   32'd3);
      chk("b2b_rdata",      bus.rdata,          m_rd);

      for (int i = 0; i < 80; i++) begin
         rop  = 3'($urandom_range(0, 7));
         rsel = $urandom_range(0, 15);
         ra   = 32'($urandom_range(0, 255));
         if (rsel == 0)      ra = 32'h100 + 32'($urandom_range(0, 4095));
         else if (rsel < 9)  ra = ra & 32'hFFFF_FFFC;
         else if (rsel < 12) ra = ra & 32'hFFFF_FFFE;
         run_one($sformatf("rnd%0d_op%0d_a%0h", i, rop, ra), rop, ra, $urandom, 1'b0, nv);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side controller for the processor's byte-addressed, big-endian data memory. It accepts one load or store request at a time from the datapath and produces the memory's edge-triggered MemRead/MemWrite strobes, stable Address/WriteData and sampled ReadData. It performs byte and halfword extraction with sign or zero extension, read-modify-write for sub-word stores, and alignment and range checks. It sits between the execute stage and the data memory.

## Interface
- MEM_BYTES, 256: data memory size in bytes. Any access with addr ≥ MEM_BYTES is an error.
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  request valid; sampled only in IDLE
- op  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
- addr  in  32  byte address
- wdata  in  32  store data; sub-word stores use the low byte or halfword
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the access completes
- err  out  1  valid with done; misaligned or out-of-range access
- rdata  out  32  load result; held until the next done
- Address  out  32  to memory; word-aligned (addr & ~3)
- WriteData  out  32  to memory
- MemWrite  out  1  to memory; the memory acts on its rising edge
- MemRead  out  1  to memory; the memory acts on its rising edge
- ReadData  in  32  from memory; big-endian word of bytes Address..Address+3

## Operation
- States: IDLE, RD, MERGE, WR, FIN. All outputs are registered.
- Reset values: state IDLE; busy, done, err, MemRead, MemWrite = 0; rdata, Address, WriteData = 0.
- In IDLE with req=1, latch op, addr and wdata, set Address = addr & ~3 and busy = 1.
  - Error (misaligned or out of range): go to FIN with err=1. No strobe is raised, and rdata is set to 0 for loads.
  - Misaligned means LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]≠0.
  - Loads and SB/SH go to RD. SW goes to WR with WriteData = wdata.
- RD: MemRead=1 for exactly one cycle. At the exit edge, ReadData is captured.
  - Loads: byte lane k = addr[1:0], where lane 0 = bits 31:24 and lane 3 = bits 7:0.
  - LB/LBU return the selected byte, sign- or zero-extended. LH/LHU return bits 31:16 (addr[1]=0) or 15:0 (addr[1]=1), extended the same way. LW returns the whole word.
  - After RD, loads go to FIN; SB/SH go to MERGE.
- MERGE: both strobes low. WriteData = captured word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]. Go to WR.
- WR: MemWrite=1 for exactly one cycle, with Address and WriteData stable for the whole cycle. Go to FIN.
- FIN: done=1 for one cycle and strobes low; then go to IDLE. err is cleared when the next request is accepted.
- Strobes are never high in two consecutive cycles. At least one low cycle separates every strobe pulse, so every access creates a fresh rising edge.
- req while busy is ignored. It is not queued.
- Reset mid-operation: next edge forces IDLE with all strobes low. A store already strobed in WR is not undone.

## Timing
- Accept edge = T0.
- LW/LH/LB/LHU/LBU: MemRead high T0→T1, done high T1→T2. rdata is valid from T1 onward.
- SW: MemWrite high T0→T1, done T1→T2.
- SB/SH: MemRead T0→T1, MERGE T1→T2, MemWrite T2→T3, done T3→T4.
- Error: done and err T0→T1.
- Next request can be accepted on the edge after done, in IDLE. Minimum issue interval: 3 cycles for loads and SW, 5 for SB/SH, 2 for errors.
- Address is stable from T0 until the next accept.

## Test plan
- SW: addr=0x10, wdata=0x11223344, then LW 0x10 → MemWrite one-cycle pulse with Address=0x10; rdata=0x11223344; LBU 0x11 → 0x00000022.
- Sign extension: SW 0x20 = 0x80FF7F01 → LB 0x20 = 0xFFFFFF80, LBU 0x21 = 0x000000FF, LH 0x20 = 0xFFFF80FF, LHU 0x22 = 0x00007F01.
- Sub-word RMW: memory word 0x30 = 0xAABBCCDD; SB 0x32 with wdata=0x12 → WriteData=0xAABB12DD; then SH 0x30 with wdata=0x5566 → word reads 0x556612DD; done on the 4th edge after accept.
- Errors: LW 0x22, SH 0x41 and LB 0x100 → done=err=1 one cycle after accept; MemRead and MemWrite stay 0 throughout; rdata=0.
- Protocol: back-to-back LW requests with req held high → strobes never high in adjacent cycles; req during busy ignored, so exactly one done per accepted request.
- Reset asserted in the MERGE state of an SB → next cycle IDLE with busy=0 and no MemWrite pulse; memory word unchanged.
